// File: rtl/edit_mode_ctrl.sv
// edit_mode_ctrl: keyboard editing sequencer for the clock/calendar counters.
// Filters PS/2 prefix bytes, tracks date/time edit mode and the active field,
// and drives the en/estado/Cambio bus plus commit/abort strobes.
module edit_mode_ctrl #(
    parameter logic [7:0]  K_UP    = 8'h73,
    parameter logic [7:0]  K_DOWN  = 8'h72,
    parameter logic [7:0]  K_RIGHT = 8'h74,
    parameter logic [7:0]  K_LEFT  = 8'h6B,
    parameter logic [7:0]  K_DATE  = 8'h05,
    parameter logic [7:0]  K_TIME  = 8'h06,
    parameter logic [7:0]  K_ENTER = 8'h5A,
    parameter logic [7:0]  K_ESC   = 8'h76,
    parameter logic [7:0]  F_DIA   = 8'h7C,
    parameter logic [7:0]  F_MES   = 8'h7D,
    parameter logic [7:0]  F_ANO   = 8'h7E,
    parameter logic [7:0]  F_HORA  = 8'h7A,
    parameter logic [7:0]  F_MIN   = 8'h79,
    parameter logic [7:0]  F_SEG   = 8'h78,
    parameter logic [31:0] TO_CYC  = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       got_data,
    input  logic [7:0] scancode,
    output logic [1:0] en,
    output logic [7:0] estado,
    output logic [7:0] Cambio,
    output logic       key_stb,
    output logic       commit,
    output logic       abort
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EDIT_D = 2'd1,
        EDIT_T = 2'd2
    } state_t;

    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam logic [7:0] PFX_EXT = 8'hE0;

    state_t      state, state_nx;
    logic [1:0]  field, field_nx;
    logic [31:0] to_cnt, to_nx;
    logic        brk, brk_nx;
    logic        ext, ext_nx;
    logic        make_vld;
    logic [7:0]  cambio_nx;
    logic        key_stb_nx, commit_nx, abort_nx;
    logic [1:0]  en_nx;
    logic [7:0]  estado_nx;

    // State register and registered outputs; reset drops straight back to RUN with no pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            field   <= 2'd0;
            to_cnt  <= 32'd0;
            brk     <= 1'b0;
            ext     <= 1'b0;
            en      <= 2'd0;
            estado  <= 8'h00;
            Cambio  <= 8'h00;
            key_stb <= 1'b0;
            commit  <= 1'b0;
            abort   <= 1'b0;
        end else begin
            state   <= state_nx;
            field   <= field_nx;
            to_cnt  <= to_nx;
            brk     <= brk_nx;
            ext     <= ext_nx;
            en      <= en_nx;
            estado  <= estado_nx;
            Cambio  <= cambio_nx;
            key_stb <= key_stb_nx;
            commit  <= commit_nx;
            abort   <= abort_nx;
        end
    end

    // Next-state logic: prefix filtering, key decode, field stepping and inactivity timeout
    always_comb begin
        state_nx   = state;
        field_nx   = field;
        to_nx      = to_cnt;
        brk_nx     = brk;
        ext_nx     = ext;
        make_vld   = 1'b0;
        cambio_nx  = Cambio;
        key_stb_nx = 1'b0;
        commit_nx  = 1'b0;
        abort_nx   = 1'b0;

        if (got_data) begin
            if (brk) begin
                brk_nx = 1'b0;
                ext_nx = 1'b0;
            end else if (scancode == PFX_BRK) begin
                brk_nx = 1'b1;
            end else if (scancode == PFX_EXT) begin
                ext_nx = 1'b1;
            end else begin
                make_vld = 1'b1;
                ext_nx   = 1'b0;
            end
        end

        if (state == RUN) begin
            to_nx = 32'd0;
            if (make_vld) begin
                if (scancode == K_DATE) begin
                    state_nx = EDIT_D;
                    field_nx = 2'd0;
                end else if (scancode == K_TIME) begin
                    state_nx = EDIT_T;
                    field_nx = 2'd0;
                end
            end
        end else if (make_vld) begin
            to_nx = 32'd0;
            if (scancode == K_RIGHT) begin
                field_nx = (field == 2'd2) ? 2'd0 : field + 2'd1;
            end else if (scancode == K_LEFT) begin
                field_nx = (field == 2'd0) ? 2'd2 : field - 2'd1;
            end else if (scancode == K_UP || scancode == K_DOWN) begin
                cambio_nx  = scancode;
                key_stb_nx = 1'b1;
            end else if (scancode == K_ENTER) begin
                commit_nx = 1'b1;
                state_nx  = RUN;
                field_nx  = 2'd0;
            end else if (scancode == K_ESC) begin
                abort_nx = 1'b1;
                state_nx = RUN;
                field_nx = 2'd0;
            end else if (scancode == K_DATE) begin
                state_nx = EDIT_D;
                field_nx = 2'd0;
            end else if (scancode == K_TIME) begin
                state_nx = EDIT_T;
                field_nx = 2'd0;
            end
        end else if (TO_CYC != 32'd0 && to_cnt == TO_CYC - 32'd1) begin
            abort_nx = 1'b1;
            state_nx = RUN;
            field_nx = 2'd0;
            to_nx    = 32'd0;
        end else begin
            to_nx = to_cnt + 32'd1;
        end
    end

    // Output decode: mode and field code derived from the next state so they update together
    always_comb begin
        en_nx     = 2'd0;
        estado_nx = 8'h00;
        case (state_nx)
            EDIT_D: begin
                en_nx = 2'd1;
                case (field_nx)
                    2'd0:    estado_nx = F_DIA;
                    2'd1:    estado_nx = F_MES;
                    default: estado_nx = F_ANO;
                endcase
            end
            EDIT_T: begin
                en_nx = 2'd2;
                case (field_nx)
                    2'd0:    estado_nx = F_HORA;
                    2'd1:    estado_nx = F_MIN;
                    default: estado_nx = F_SEG;
                endcase
            end
            default: begin
                en_nx     = 2'd0;
                estado_nx = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_edit_mode_ctrl.sv
// tb_edit_mode_ctrl: directed checks of mode/field sequencing, prefix filtering,
// strobes, inactivity timeout and asynchronous reset for edit_mode_ctrl.
module tb_edit_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       got_data;
    logic [7:0] scancode;
    logic [1:0] en;
    logic [7:0] estado;
    logic [7:0] Cambio;
    logic       key_stb;
    logic       commit;
    logic       abort;

    int testsRun  = 0;
    int testsFail = 0;

    edit_mode_ctrl #(.TO_CYC(32'd16)) dut (
        .clk      (clk),
        .rst      (rst),
        .got_data (got_data),
        .scancode (scancode),
        .en       (en),
        .estado   (estado),
        .Cambio   (Cambio),
        .key_stb  (key_stb),
        .commit   (commit),
        .abort    (abort)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte with a single-cycle got_data strobe; returns on the negedge after it was taken
    task automatic applyStimulus(input logic [7:0] code);
        @(negedge clk);
        got_data = 1'b1;
        scancode = code;
        @(negedge clk);
        got_data = 1'b0;
        scancode = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [31:0] acc;

    initial begin
        rst      = 1'b1;
        got_data = 1'b0;
        scancode = 8'h00;
        #1 rst = 1'b0;
        #3;
        checkOutput("reset_en",     {30'd0, en}, 32'd0);
        checkOutput("reset_estado", {24'd0, estado}, 32'd0);
        checkOutput("reset_strobes", {29'd0, key_stb, commit, abort}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset: nothing may move for 100 cycles
        acc = 32'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = acc | {14'd0, en, estado, Cambio[5:0], key_stb, commit}
                      | {31'd0, abort} | {24'd0, Cambio};
        end
        checkOutput("idle_100", acc, 32'd0);

        // Date edit, move right, increment
        applyStimulus(8'h05);
        checkOutput("date_en",     {30'd0, en}, 32'd1);
        checkOutput("date_estado", {24'd0, estado}, 32'h7C);
        applyStimulus(8'h74);
        checkOutput("right_estado", {24'd0, estado}, 32'h7D);
        applyStimulus(8'h73);
        checkOutput("up_stb",    {31'd0, key_stb}, 32'd1);
        checkOutput("up_cambio", {24'd0, Cambio}, 32'h73);
        checkOutput("up_estado", {24'd0, estado}, 32'h7D);
        idleCycles(1);
        checkOutput("up_stb_clear",  {31'd0, key_stb}, 32'd0);
        checkOutput("cambio_hold",   {24'd0, Cambio}, 32'h73);

        // Switch to time edit, wrap left 0->2 then right 2->0, decrement
        applyStimulus(8'h06);
        checkOutput("time_en",     {30'd0, en}, 32'd2);
        checkOutput("time_estado", {24'd0, estado}, 32'h7A);
        applyStimulus(8'h6B);
        checkOutput("left_wrap", {24'd0, estado}, 32'h78);
        applyStimulus(8'h74);
        checkOutput("right_wrap", {24'd0, estado}, 32'h7A);
        applyStimulus(8'h72);
        checkOutput("down_stb",    {31'd0, key_stb}, 32'd1);
        checkOutput("down_cambio", {24'd0, Cambio}, 32'h72);
        applyStimulus(8'h76);
        checkOutput("esc_abort",  {29'd0, key_stb, commit, abort}, 32'd1);
        checkOutput("esc_en",     {30'd0, en}, 32'd0);
        checkOutput("esc_estado", {24'd0, estado}, 32'h00);
        idleCycles(1);
        checkOutput("esc_pulse_once", {31'd0, abort}, 32'd0);

        // Prefix filtering: break sequences discarded, extended code taken
        applyStimulus(8'h05);
        applyStimulus(8'hF0);
        applyStimulus(8'h05);
        checkOutput("brk_en",     {30'd0, en}, 32'd1);
        checkOutput("brk_estado", {24'd0, estado}, 32'h7C);
        applyStimulus(8'hF0);
        applyStimulus(8'h73);
        checkOutput("brk_no_stb", {31'd0, key_stb}, 32'd0);
        applyStimulus(8'hE0);
        applyStimulus(8'h74);
        checkOutput("ext_right", {24'd0, estado}, 32'h7D);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h74);
        checkOutput("ext_brk_discard", {24'd0, estado}, 32'h7D);
        applyStimulus(8'h5A);
        checkOutput("enter_commit", {29'd0, key_stb, commit, abort}, 32'd2);
        checkOutput("enter_en",     {30'd0, en}, 32'd0);

        // Keys in RUN other than F1/F2 do nothing
        applyStimulus(8'h73);
        checkOutput("run_no_stb", {29'd0, key_stb, commit, abort}, 32'd0);
        checkOutput("run_en",     {30'd0, en}, 32'd0);

        // Timeout: abort exactly 16 cycles after entering edit
        applyStimulus(8'h05);
        acc = 32'd0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            acc = acc | {31'd0, abort};
        end
        checkOutput("to_quiet",  acc, 32'd0);
        checkOutput("to_pre_en", {30'd0, en}, 32'd1);
        @(negedge clk);
        checkOutput("to_abort",  {29'd0, key_stb, commit, abort}, 32'd1);
        checkOutput("to_en",     {30'd0, en}, 32'd0);
        idleCycles(1);
        checkOutput("to_pulse_once", {31'd0, abort}, 32'd0);

        // Key landing on the timeout cycle wins
        applyStimulus(8'h05);
        idleCycles(14);
        applyStimulus(8'h74);
        checkOutput("to_key_no_abort", {31'd0, abort}, 32'd0);
        checkOutput("to_key_estado",   {24'd0, estado}, 32'h7D);
        idleCycles(1);
        checkOutput("to_key_later", {30'd0, en, abort}, 32'd2);
        applyStimulus(8'h76);

        // Asynchronous reset during time edit
        applyStimulus(8'h06);
        checkOutput("pre_rst_en", {30'd0, en}, 32'd2);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_en",     {30'd0, en}, 32'd0);
        checkOutput("async_estado", {24'd0, estado}, 32'h00);
        checkOutput("async_pulses", {29'd0, key_stb, commit, abort}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idleCycles(2);
        checkOutput("post_rst", {22'd0, en, estado, commit, abort}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
